wf_capture_buffer: RTL
======================

// Module: wf_capture_buffer
// PURPOSE
// - Consumes decimated I/Q samples from the two waterfall CIC decimators (shared strobe) and captures a block of N samples into on-chip RAM.
// - Software arms a capture, waits for capture_done, then reads the block out sequentially over the register interface.
// - Sits directly downstream of the waterfall CIC pair and upstream of the CPU readout path.
// PARAMETERS
// - DATA_WIDTH  16  width of each I and Q sample (equals CIC OUT_WIDTH)
// - ADDR_WIDTH  10  RAM address width; depth = 2**ADDR_WIDTH words of {I,Q}
// - SETTLE      5   post-arm samples discarded (equals CIC STAGES); used only with the optional feature
// PORTS
// - clock          in   1            single clock for all logic
// - reset_n        in   1            asynchronous, active-low reset
// - in_strobe      in   1            one-cycle valid pulse from the CIC out_strobe
// - in_i           in   DATA_WIDTH   signed I sample, valid with in_strobe
// - in_q           in   DATA_WIDTH   signed Q sample, valid with in_strobe
// - capture_start  in   1            one-cycle pulse: arm a new capture
// - capture_abort  in   1            one-cycle pulse: stop the capture and return to IDLE
// - nsamples       in   ADDR_WIDTH   samples to capture; 0 means full depth; sampled at capture_start
// - rd_reset       in   1            pulse: read address <= 0
// - rd_strobe      in   1            pulse: present the word at rd_addr, then rd_addr++
// - rd_data        out  2*DATA_WIDTH {I,Q} read word, I in upper half
// - capture_busy   out  1            high in SETTLE or CAPTURE
// - capture_done   out  1            high in DONE
// - wr_count       out  ADDR_WIDTH+1 samples written in the current or last capture
// BEHAVIOUR
// - Reset (async assert, sync-safe release): state=IDLE; rd_data=0, busy=0, done=0, wr_count=0, rd_addr=0. RAM contents are not reset.
// - FSM states: IDLE, SETTLE, CAPTURE, DONE.
//   - IDLE/DONE + capture_start -> SETTLE (or CAPTURE when the feature is off). wr_addr=0, wr_count=0, target latched.
//   - SETTLE: discard in_strobe samples; after SETTLE strobes -> CAPTURE. The first captured sample is strobe SETTLE+1.
//   - CAPTURE: each in_strobe writes {in_i,in_q} to mem[wr_addr], then wr_addr++ and wr_count++. The write that makes wr_count==target -> DONE on the next cycle.
// - Target = (nsamples==0) ? 2**ADDR_WIDTH : nsamples.
// - capture_start in SETTLE/CAPTURE restarts the capture: counters clear, state -> SETTLE/CAPTURE.
// - capture_abort wins over capture_start and over a same-cycle in_strobe: state -> IDLE, no write, wr_count holds.
// - An in_strobe in IDLE/DONE is ignored.
// - Read path: one-cycle latency. rd_strobe at cycle t -> rd_data = mem[rd_addr] at t+1; rd_addr++ wraps mod depth.
//   - rd_reset beats a same-cycle rd_strobe: the address clears and no read occurs.
//   - rd_data holds between strobes.
//   - Reads are allowed in any state. A read in CAPTURE of an unwritten address returns stale RAM contents.
//   - On a same-address read/write collision, the read returns the old data (read-first).
// - No arithmetic on the samples: bit-exact storage. wr_count saturates at the target.
// CONFIGURATION
// - WF_CIC_SETTLE_DISCARD_EN defined: the SETTLE state exists and discards SETTLE samples after each arm, flushing CIC transients after a decimation change.
// - Macro undefined: SETTLE state and counter are removed; capture_start goes directly to CAPTURE; the SETTLE parameter is ignored.
// STRUCTURE
// - Shared package wf_pkg: state enum (IDLE/SETTLE/CAPTURE/DONE) and WF_IQ_WIDTH = 2*DATA_WIDTH.
// - Sub-module wf_sdp_ram: simple dual-port RAM, one write port and one read-first registered read port, inferred BRAM.
// - This top holds the FSM, write counters and read address logic.
// TESTING
// - Reset mid-CAPTURE (reset_n low for 3 cycles) -> state IDLE, busy=0, done=0, wr_count=0, rd_data=0.
// - nsamples=8, feature off, in_i=k, in_q=-k for k=1..10 -> done after the 8th strobe, wr_count=8; readout gives 0x0001FFFF ... 0x0008FFF8.
// - Feature on, SETTLE=5, nsamples=4, inputs k=1..12 -> captured words are k=6..9; busy is high for 9 strobes.
// - nsamples=0, ADDR_WIDTH=4 -> 16 samples captured; 17 rd_strobes -> the 17th returns word 0 (wrap).
// - capture_abort on the same cycle as in_strobe in CAPTURE after 3 writes -> IDLE, wr_count=3, RAM address 3 not written.
// - capture_start during CAPTURE after 5 writes -> counters restart; rd_reset together with rd_strobe -> rd_addr=0 and rd_data unchanged.

Source files
------------

// File: rtl/wf_pkg.sv
// Shared types for the waterfall capture path: FSM state encoding and {I,Q} word width.
package wf_pkg;

    localparam int WF_DATA_WIDTH = 16;
    localparam int WF_IQ_WIDTH   = 2 * WF_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } wf_state_e;

endpackage

// File: rtl/wf_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module wf_sdp_ram
    import wf_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_WIDTH = WF_IQ_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WORD_WIDTH-1:0] rdata_o
);

    logic [WORD_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
    logic [WORD_WIDTH-1:0] rdata_q;

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-blocking update gives old data on a same-address collision.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wf_capture_buffer.sv
// Waterfall I/Q block capture: arm, optional settle discard, capture N samples, sequential readout.
// Optional settle-discard state enabled by defining WF_CIC_SETTLE_DISCARD_EN.
//
// state   | meaning
// IDLE    | waiting for capture_start
// SETTLE  | discarding post-arm CIC transients (feature build only)
// CAPTURE | writing each strobed sample to RAM
// DONE    | block complete, waiting for readout or re-arm
module wf_capture_buffer
    import wf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int SETTLE     = 5
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_strobe,
    input  logic [DATA_WIDTH-1:0]   in_i,
    input  logic [DATA_WIDTH-1:0]   in_q,
    input  logic                    capture_start,
    input  logic                    capture_abort,
    input  logic [ADDR_WIDTH-1:0]   nsamples,
    input  logic                    rd_reset,
    input  logic                    rd_strobe,
    output logic [2*DATA_WIDTH-1:0] rd_data,
    output logic                    capture_busy,
    output logic                    capture_done,
    output logic [ADDR_WIDTH:0]     wr_count
);

`ifdef WF_CIC_SETTLE_DISCARD_EN
    localparam int SETTLE_LEN = SETTLE;
    localparam int SCW        = (SETTLE_LEN < 2) ? 1 : $clog2(SETTLE_LEN + 1);
`else
    localparam int SETTLE_LEN = 0 * SETTLE;
`endif
    localparam bit USE_SETTLE = (SETTLE_LEN > 0);

    wf_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]   wr_count_q, wr_count_d;
    logic [ADDR_WIDTH:0]   target_q, target_d;
    logic [ADDR_WIDTH:0]   arm_target;
    logic                  wr_en;
    logic                  rd_en;
`ifdef WF_CIC_SETTLE_DISCARD_EN
    logic [SCW-1:0]        settle_q, settle_d;
`endif

    assign arm_target = (nsamples == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, nsamples};

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        wr_count_d = wr_count_q;
        target_d   = target_q;
        wr_en      = 1'b0;
`ifdef WF_CIC_SETTLE_DISCARD_EN
        settle_d   = settle_q;
`endif
        // Abort outranks a re-arm and any same-cycle sample.
        if (capture_abort) begin
            state_d = ST_IDLE;
        end else if (capture_start) begin
            state_d    = USE_SETTLE ? ST_SETTLE : ST_CAPTURE;
            wr_addr_d  = '0;
            wr_count_d = '0;
            target_d   = arm_target;
`ifdef WF_CIC_SETTLE_DISCARD_EN
            settle_d   = SCW'(SETTLE_LEN);
`endif
        end else if (in_strobe) begin
            case (state_q)
`ifdef WF_CIC_SETTLE_DISCARD_EN
                ST_SETTLE: begin
                    settle_d = settle_q - 1'b1;
                    if (settle_q == SCW'(1)) begin
                        state_d = ST_CAPTURE;
                    end
                end
`endif
                ST_CAPTURE: begin
                    wr_en      = 1'b1;
                    wr_addr_d  = wr_addr_q + 1'b1;
                    wr_count_d = wr_count_q + 1'b1;
                    if ((wr_count_q + 1'b1) == target_q) begin
                        state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_en     = rd_strobe & ~rd_reset;
    assign rd_addr_d = rd_reset ? '0 : (rd_en ? rd_addr_q + 1'b1 : rd_addr_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wr_count_q <= '0;
            target_q   <= '0;
`ifdef WF_CIC_SETTLE_DISCARD_EN
            settle_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wr_count_q <= wr_count_d;
            target_q   <= target_d;
`ifdef WF_CIC_SETTLE_DISCARD_EN
            settle_q   <= settle_d;
`endif
        end
    end

    wf_sdp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (2 * DATA_WIDTH)
    ) u_ram (
        .clock   (clock),
        .reset_n (reset_n),
        .we_i    (wr_en),
        .waddr_i (wr_addr_q),
        .wdata_i ({in_i, in_q}),
        .re_i    (rd_en),
        .raddr_i (rd_addr_q),
        .rdata_o (rd_data)
    );

    assign capture_busy = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
    assign capture_done = (state_q == ST_DONE);
    assign wr_count     = wr_count_q;

endmodule
